// File: rtl/minterm_sweeper.sv
// Sweeps a 4-input function block through codes 0..15, captures its output
// into a truth table and compares the table against a fixed expected value.
module minterm_sweeper #(
    parameter int          HOLD_CYCLES = 2,
    parameter logic [15:0] EXPECTED    = 16'hF888
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        f_in,
    output logic [3:0]  abcd_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic        match,
    output logic [4:0]  mismatches
);

    // state | meaning
    // IDLE  | waiting for start after reset
    // SWEEP | presenting codes 0..15, sampling f at the end of each hold window
    // DONE  | table complete, result held until start or rst

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t            state_q, state_n;
    logic [3:0]        abcd_q, abcd_n;
    logic [15:0]       table_q, table_n;
    logic [CNT_W-1:0]  hold_q, hold_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            abcd_q  <= 4'd0;
            table_q <= 16'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_n;
            abcd_q  <= abcd_n;
            table_q <= table_n;
            hold_q  <= hold_n;
        end
    end

    always_comb begin
        state_n = state_q;
        abcd_n  = abcd_q;
        table_n = table_q;
        hold_n  = hold_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_n = SWEEP;
                    abcd_n  = 4'd0;
                    table_n = 16'd0;
                    hold_n  = '0;
                end
            end
            SWEEP: begin
                if (hold_q == HOLD_LAST) begin
                    table_n[abcd_q] = f_in;
                    hold_n          = '0;
                    // Code 15 is the last one; abcd stays at 15 in DONE.
                    if (abcd_q == 4'hF) begin
                        state_n = DONE;
                    end else begin
                        abcd_n = abcd_q + 4'd1;
                    end
                end else begin
                    hold_n = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign abcd_out    = abcd_q;
    assign truth_table = table_q;
    assign busy        = (state_q == SWEEP);
    assign done        = (state_q == DONE);
    assign match       = done && (table_q == EXPECTED);
    assign mismatches  = done ? 5'($countones(table_q ^ EXPECTED)) : 5'd0;

endmodule
